// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store path: funct3 access types, LSU FSM states
// and the per-op legality/alignment helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_e;

    // Unsigned variants only exist for loads; stores accept B/H/W.
    function automatic logic type_legal(input logic [2:0] mtype, input logic is_load);
        logic ok;
        case (mtype)
            MT_B, MT_H, MT_W: ok = 1'b1;
            MT_BU, MT_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] mtype, input logic [1:0] addr_lo);
        logic ok;
        case (mtype)
            MT_H, MT_HU: ok = ~addr_lo[0];
            MT_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting: store byte enables / replicated write data, and load lane
// extraction with sign or zero extension. Purely combinational.
module lsu_lane_fmt
    import mem_pkg::*;
(
    input  logic [2:0]  mem_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_load_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = '0;
        if (!is_load_i) begin
            case (mem_type_i)
                MT_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                MT_H: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = store_data_i;
                end
            endcase
        end
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (mem_type_i)
            MT_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            MT_BU:   load_data_o = {24'h0, byte_sel};
            MT_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            MT_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store ops into a word-aligned req/ack
// bus transaction, stalls the pipeline while it is outstanding, and formats load data.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [2:0]  memType_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] storeData_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_mem,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW:0] TMO_LIM = TIMEOUT_CYCLES[CW:0];

    lsu_state_e state_q, state_d;

    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [2:0]    type_q, type_d;
    logic [1:0]    lane_q, lane_d;
    logic          is_load_q, is_load_d;
    logic          flush_pend_q, flush_pend_d;
    logic [31:0]   load_data_q, load_data_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;

    logic          in_idle;
    logic          op_valid, op_both, op_legal, op_aligned;
    logic          launch, idle_err, tmo_hit;
    logic [CW:0]   cnt_inc;

    logic [2:0]    fmt_type;
    logic [1:0]    fmt_lo;
    logic          fmt_is_load;
    logic [3:0]    fmt_be;
    logic [31:0]   fmt_wdata;
    logic [31:0]   fmt_load;

    // The formatter sees the live EX/MEM op in IDLE (store lanes) and the latched op
    // in BUSY (load extraction), so a single instance serves both directions.
    assign in_idle     = (state_q == IDLE);
    assign fmt_type    = in_idle ? memType_in    : type_q;
    assign fmt_lo      = in_idle ? addr_in[1:0]  : lane_q;
    assign fmt_is_load = in_idle ? memRead_in    : is_load_q;

    lsu_lane_fmt u_lane_fmt (
        .mem_type_i   (fmt_type),
        .addr_lo_i    (fmt_lo),
        .is_load_i    (fmt_is_load),
        .store_data_i (storeData_in),
        .rdata_i      (mem_rdata),
        .be_o         (fmt_be),
        .wdata_o      (fmt_wdata),
        .load_data_o  (fmt_load)
    );

    assign op_valid   = memRead_in ^ memWrite_in;
    assign op_both    = memRead_in & memWrite_in;
    assign op_legal   = op_valid & type_legal(memType_in, memRead_in);
    assign op_aligned = is_aligned(memType_in, addr_in[1:0]);

    // The timed-out instruction is still presented during the error cycle; it must
    // not be re-launched there.
    assign launch   = in_idle & ~flush & ~tmo_err_q & op_legal & op_aligned;
    assign idle_err = in_idle & ~flush & (op_both | (op_valid & (~op_legal | ~op_aligned)));

    assign cnt_inc = {1'b0, tmo_cnt_q} + {{CW{1'b0}}, 1'b1};
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO_LIM);

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        type_d       = type_q;
        lane_d       = lane_q;
        is_load_d    = is_load_q;
        flush_pend_d = flush_pend_q;
        load_data_d  = load_data_q;
        tmo_cnt_d    = tmo_cnt_q;
        tmo_err_d    = 1'b0;
        stall_mem    = 1'b0;
        load_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                stall_mem = launch;
                if (launch) begin
                    state_d      = BUSY;
                    mem_req_d    = 1'b1;
                    mem_we_d     = memWrite_in;
                    mem_addr_d   = {addr_in[31:2], 2'b00};
                    mem_wdata_d  = fmt_wdata;
                    mem_be_d     = fmt_be;
                    type_d       = memType_in;
                    lane_d       = addr_in[1:0];
                    is_load_d    = memRead_in;
                    flush_pend_d = 1'b0;
                    tmo_cnt_d    = '0;
                end
            end
            BUSY: begin
                stall_mem    = 1'b1;
                flush_pend_d = flush_pend_q | flush;
                if (mem_ack || tmo_hit) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    tmo_cnt_d   = '0;
                end
                if (mem_ack) begin
                    state_d = DONE;
                    if (is_load_q && !flush_pend_q && !flush) begin
                        load_data_d = fmt_load;
                    end
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_d = cnt_inc[CW-1:0];
                end
            end
            DONE: begin
                load_valid = is_load_q & ~flush_pend_q & ~flush;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            type_q       <= '0;
            lane_q       <= '0;
            is_load_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            load_data_q  <= '0;
            tmo_cnt_q    <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            type_q       <= type_d;
            lane_q       <= lane_d;
            is_load_q    <= is_load_d;
            flush_pend_q <= flush_pend_d;
            load_data_q  <= load_data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign load_data  = load_data_q;
    assign access_err = idle_err | tmo_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: default-timeout instance for the main flows and a
// short-timeout instance for bus-timeout behaviour.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        memRead_in, memWrite_in;
    logic [2:0]  memType_in;
    logic [31:0] addr_in, storeData_in;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        en_m, en_t;

    logic        m_rd, m_wr, t_rd, t_wr;

    logic        mem_req, mem_we, stall_mem, load_valid, access_err;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;

    logic        t_req, t_we, t_stall, t_valid, t_err;
    logic [31:0] t_addr, t_wdata, t_ldata;
    logic [3:0]  t_be;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned stall_cnt;

    assign m_rd = memRead_in & en_m;
    assign m_wr = memWrite_in & en_m;
    assign t_rd = memRead_in & en_t;
    assign t_wr = memWrite_in & en_t;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .memRead_in(m_rd), .memWrite_in(m_wr), .memType_in(memType_in),
        .addr_in(addr_in), .storeData_in(storeData_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_mem(stall_mem), .load_data(load_data),
        .load_valid(load_valid), .access_err(access_err)
    );

    mem_stage_lsu #(.TIMEOUT_CYCLES(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .memRead_in(t_rd), .memWrite_in(t_wr), .memType_in(memType_in),
        .addr_in(addr_in), .storeData_in(storeData_in),
        .mem_req(t_req), .mem_we(t_we), .mem_addr(t_addr),
        .mem_wdata(t_wdata), .mem_be(t_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_mem(t_stall), .load_data(t_ldata),
        .load_valid(t_valid), .access_err(t_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d);
        memRead_in   = rd;
        memWrite_in  = wr;
        memType_in   = t;
        addr_in      = a;
        storeData_in = d;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        en_m = 1'b1; en_t = 1'b0;
        idle_in();
        #12;
        check("rst_req",    32'(mem_req),    32'h0);
        check("rst_be",     32'(mem_be),     32'h0);
        check("rst_stall",  32'(stall_mem),  32'h0);
        check("rst_valid",  32'(load_valid), 32'h0);
        check("rst_err",    32'(access_err), 32'h0);
        check("rst_addr",   mem_addr,        32'h0);
        check("rst_wdata",  mem_wdata,       32'h0);
        check("rst_ldata",  load_data,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB 0x1003, ack in first BUSY cycle
        cyc(); drive(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0); #1;
        check("lb_c1_stall", 32'(stall_mem), 32'h1);
        check("lb_c1_req",   32'(mem_req),   32'h0);
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h80FF_1234; #1;
        check("lb_c2_req",   32'(mem_req),   32'h1);
        check("lb_c2_addr",  mem_addr,       32'h1000);
        check("lb_c2_be",    32'(mem_be),    32'hF);
        check("lb_c2_we",    32'(mem_we),    32'h0);
        check("lb_c2_stall", 32'(stall_mem), 32'h1);
        cyc(); mem_ack = 1'b0; #1;
        check("lb_c3_valid", 32'(load_valid), 32'h1);
        check("lb_c3_data",  load_data,       32'hFFFF_FF80);
        check("lb_c3_stall", 32'(stall_mem),  32'h0);
        check("lb_c3_req",   32'(mem_req),    32'h0);
        cyc(); idle_in(); #1;
        check("lb_c4_valid", 32'(load_valid), 32'h0);
        check("lb_c4_data",  load_data,       32'hFFFF_FF80);

        // SH 0x2002
        cyc(); drive(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF); #1;
        check("sh_c1_stall", 32'(stall_mem), 32'h1);
        cyc(); mem_ack = 1'b1; #1;
        check("sh_req",   32'(mem_req), 32'h1);
        check("sh_we",    32'(mem_we),  32'h1);
        check("sh_be",    32'(mem_be),  32'hC);
        check("sh_wdata", mem_wdata,    32'hBEEF_BEEF);
        check("sh_addr",  mem_addr,     32'h2000);
        cyc(); mem_ack = 1'b0; #1;
        check("sh_done_valid", 32'(load_valid), 32'h0);
        check("sh_done_ldata", load_data,       32'hFFFF_FF80);
        check("sh_done_stall", 32'(stall_mem),  32'h0);
        cyc(); idle_in(); #1;
        check("sh_after_valid", 32'(load_valid), 32'h0);

        // LW misaligned, illegal ops, flush in IDLE
        cyc(); drive(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0); #1;
        check("lw_mis_err",   32'(access_err), 32'h1);
        check("lw_mis_stall", 32'(stall_mem),  32'h0);
        cyc(); #1;
        check("lw_mis_req",   32'(mem_req),    32'h0);
        cyc(); drive(1'b1, 1'b1, 3'b010, 32'h3000, 32'h0); #1;
        check("both_err",   32'(access_err), 32'h1);
        check("both_stall", 32'(stall_mem),  32'h0);
        cyc(); drive(1'b0, 1'b1, 3'b100, 32'h3000, 32'h0); #1;
        check("sbu_err", 32'(access_err), 32'h1);
        cyc(); drive(1'b1, 1'b0, 3'b011, 32'h3000, 32'h0); #1;
        check("ld011_err", 32'(access_err), 32'h1);
        cyc(); drive(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0); flush = 1'b1; #1;
        check("flush_idle_err", 32'(access_err), 32'h0);
        cyc(); drive(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0); #1;
        check("flush_idle_stall", 32'(stall_mem), 32'h0);
        cyc(); flush = 1'b0; idle_in(); #1;
        check("flush_idle_req", 32'(mem_req), 32'h0);

        // LHU 0x4002, ack in the fourth BUSY cycle
        cyc(); drive(1'b1, 1'b0, 3'b101, 32'h4002, 32'h0); mem_rdata = 32'hABCD_0000; #1;
        stall_cnt = 32'(stall_mem);
        for (int i = 0; i < 4; i++) begin
            cyc(); mem_ack = (i == 3); #1;
            check("lhu_busy_req",  32'(mem_req), 32'h1);
            check("lhu_busy_addr", mem_addr,     32'h4000);
            stall_cnt += 32'(stall_mem);
        end
        cyc(); mem_ack = 1'b0; #1;
        stall_cnt += 32'(stall_mem);
        check("lhu_stall_cycles", stall_cnt,        32'd5);
        check("lhu_data",         load_data,        32'h0000_ABCD);
        check("lhu_valid",        32'(load_valid),  32'h1);
        cyc(); idle_in(); #1;

        // Timeout on the TIMEOUT_CYCLES=3 instance, then a store is accepted
        en_m = 1'b0; en_t = 1'b1;
        cyc(); drive(1'b1, 1'b0, 3'b000, 32'h5000, 32'h0); #1;
        check("tmo_c1_stall", 32'(t_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            check("tmo_busy_req",   32'(t_req),   32'h1);
            check("tmo_busy_stall", 32'(t_stall), 32'h1);
            check("tmo_busy_err",   32'(t_err),   32'h0);
        end
        cyc(); #1;
        check("tmo_req_drop", 32'(t_req),   32'h0);
        check("tmo_err",      32'(t_err),   32'h1);
        check("tmo_stall",    32'(t_stall), 32'h0);
        cyc(); idle_in(); #1;
        check("tmo_err_once", 32'(t_err), 32'h0);
        check("tmo_req_idle", 32'(t_req), 32'h0);
        cyc(); drive(1'b0, 1'b1, 3'b010, 32'h6004, 32'h1122_3344); #1;
        check("tmo_next_stall", 32'(t_stall), 32'h1);
        cyc(); mem_ack = 1'b1; #1;
        check("tmo_next_req",   32'(t_req),  32'h1);
        check("tmo_next_be",    32'(t_be),   32'hF);
        check("tmo_next_wdata", t_wdata,     32'h1122_3344);
        check("tmo_next_addr",  t_addr,      32'h6004);
        cyc(); mem_ack = 1'b0; #1;
        check("tmo_next_done_stall", 32'(t_stall), 32'h0);
        check("tmo_next_done_err",   32'(t_err),   32'h0);
        cyc(); idle_in(); en_m = 1'b1; en_t = 1'b0; #1;

        // Flush during BUSY of LW 0x7000
        cyc(); drive(1'b1, 1'b0, 3'b010, 32'h7000, 32'h0); #1;
        check("fl_c1_stall", 32'(stall_mem), 32'h1);
        cyc(); flush = 1'b1; #1;
        check("fl_c2_req", 32'(mem_req), 32'h1);
        cyc(); flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678; #1;
        check("fl_c3_req",   32'(mem_req),   32'h1);
        check("fl_c3_stall", 32'(stall_mem), 32'h1);
        cyc(); mem_ack = 1'b0; #1;
        check("fl_done_valid", 32'(load_valid), 32'h0);
        check("fl_done_ldata", load_data,       32'h0000_ABCD);
        check("fl_done_req",   32'(mem_req),    32'h0);
        cyc(); idle_in(); #1;

        // LBU 0x8001 with flush asserted in DONE
        cyc(); drive(1'b1, 1'b0, 3'b100, 32'h8001, 32'h0); #1;
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h0000_8000; #1;
        cyc(); mem_ack = 1'b0; flush = 1'b1; #1;
        check("lbu_flush_done_valid", 32'(load_valid), 32'h0);
        cyc(); flush = 1'b0; idle_in(); #1;
        check("lbu_data", load_data, 32'h0000_0080);

        // Reset mid-BUSY
        cyc(); drive(1'b1, 1'b0, 3'b010, 32'h9000, 32'h0); #1;
        cyc(); #1;
        check("rb_busy_req", 32'(mem_req), 32'h1);
        #2; rst_n = 1'b0; idle_in(); #1;
        check("rb_req",   32'(mem_req),   32'h0);
        check("rb_stall", 32'(stall_mem), 32'h0);
        check("rb_addr",  mem_addr,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); drive(1'b1, 1'b0, 3'b000, 32'h9000, 32'h0); #1;
        check("rb_new_stall", 32'(stall_mem), 32'h1);
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h0000_00AA; #1;
        check("rb_new_req", 32'(mem_req), 32'h1);
        cyc(); mem_ack = 1'b0; #1;
        check("rb_new_data",  load_data,       32'hFFFF_FFAA);
        check("rb_new_valid", 32'(load_valid), 32'h1);
        cyc(); idle_in(); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
